// File: rtl/trace_pkg.sv
// Shared types and default sizing for the trace checker.
// Memory words are packed {skip, data}, matching entry_t.
package trace_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_DIV   = 2;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic                 skip;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/trace_mem.sv
// Expected-value trace store: one synchronous write port, one async read.
// No reset, so a loaded trace survives rst.
module trace_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH:0]   wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH:0]   rdata
);

    logic [WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_checker.sv
// Compares obs against a preloaded trace once every DIV clocks and
// reports per-sample errors, a saturating count and the first mismatch.
module trace_checker
    import trace_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIV   = DEF_DIV,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_we,
    input  logic [IDX_W-1:0] load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_skip,
    input  logic [IDX_W:0]   trace_len,
    input  logic             start,
    input  logic [WIDTH-1:0] obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_valid,
    output logic [IDX_W-1:0] err_index,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_index,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_obs
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    state_t state, state_n;

    logic [IDX_W:0]   len_q;
    logic [IDX_W:0]   len_clamp;
    logic [IDX_W-1:0] idx;
    logic [DIV_W-1:0] div;
    logic             active;
    logic [WIDTH:0]   rd_word;
    logic             go;
    logic             mem_we;
    logic             strobe;
    logic             miss;
    logic             last;

    // Compare result registered on the strobe edge, applied one edge later.
    logic             cmp_valid;
    logic             cmp_miss;
    logic             cmp_last;
    logic [IDX_W-1:0] cmp_idx;
    logic [WIDTH-1:0] cmp_exp;
    logic [WIDTH-1:0] cmp_obs;

    assign go        = start && (state != RUN);
    assign mem_we    = load_we && (state == IDLE) && !start;
    assign len_clamp = (trace_len > DEPTH_L) ? DEPTH_L : trace_len;
    assign strobe    = active && (div == DIV_LAST);
    assign miss      = !(rd_word[WIDTH] || (obs === rd_word[WIDTH-1:0]));
    assign last      = ({1'b0, idx} == (len_q - (IDX_W + 1)'(1)));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    trace_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata ({load_skip, load_data}),
        .raddr (idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (go) state_n = RUN;
            RUN:     if (cmp_valid && cmp_last) state_n = DONE;
            DONE:    if (go) state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q           <= '0;
            idx             <= '0;
            div             <= '0;
            active          <= 1'b0;
            cmp_valid       <= 1'b0;
            cmp_miss        <= 1'b0;
            cmp_last        <= 1'b0;
            cmp_idx         <= '0;
            cmp_exp         <= '0;
            cmp_obs         <= '0;
            pass            <= 1'b0;
            err_valid       <= 1'b0;
            err_index       <= '0;
            err_count       <= '0;
            first_err_index <= '0;
            first_err_exp   <= '0;
            first_err_obs   <= '0;
        end else begin
            cmp_valid <= 1'b0;
            err_valid <= 1'b0;
            if (go) begin
                len_q           <= len_clamp;
                idx             <= '0;
                div             <= '0;
                err_count       <= '0;
                first_err_index <= '0;
                first_err_exp   <= '0;
                first_err_obs   <= '0;
                pass            <= 1'b0;
                active          <= (len_clamp != '0);
                // An empty trace finishes through the same commit path.
                cmp_valid       <= (len_clamp == '0);
                cmp_miss        <= 1'b0;
                cmp_last        <= 1'b1;
            end else begin
                if (active) begin
                    div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
                end
                if (strobe) begin
                    cmp_valid <= 1'b1;
                    cmp_miss  <= miss;
                    cmp_last  <= last;
                    cmp_idx   <= idx;
                    cmp_exp   <= rd_word[WIDTH-1:0];
                    cmp_obs   <= obs;
                    idx       <= idx + IDX_W'(1);
                    if (last) begin
                        active <= 1'b0;
                    end
                end
                if (cmp_valid) begin
                    if (cmp_miss) begin
                        err_valid <= 1'b1;
                        err_index <= cmp_idx;
                        if (err_count != '1) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        if (err_count == '0) begin
                            first_err_index <= cmp_idx;
                            first_err_exp   <= cmp_exp;
                            first_err_obs   <= cmp_obs;
                        end
                    end
                    if (cmp_last) begin
                        pass <= !cmp_miss && (err_count == '0);
                    end
                end
            end
        end
    end

endmodule

// File: doc/trace_checker.md
# trace_checker

Synthesizable trace checker that compares a monitored bus value against a preloaded expected-value trace. One comparison happens every DIV clock cycles. The block latches the first mismatch and reports per-sample error pulses and a saturating error count. It sits beside the processor in system-level benches and FPGA self-test builds, where it replaces hand-written per-sample compare loops. It generalises that checking to any WIDTH and DEPTH, adds a programmable sample divider, per-entry don't-care masking, and a pass/fail result.

## Interface
Parameters:
- WIDTH, 8, width of the observed value and of each expected entry
- DEPTH, 32, number of trace entries
- DIV, 2, clocks per sample strobe (≥1)
- CNT_W, 8, width of the error counter
- IDX_W, $clog2(DEPTH), width of the trace index

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- load_we  in  1  write one trace entry (accepted only in IDLE)
- load_addr  in  IDX_W  entry index to write
- load_data  in  WIDTH  expected value
- load_skip  in  1  entry is don't-care; it always matches
- trace_len  in  IDX_W+1  number of entries to check; sampled on start
- start  in  1  begin a run (accepted only in IDLE or DONE)
- obs  in  WIDTH  monitored value (e.g. processor Address)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done; 1 = zero mismatches
- err_valid  out  1  one-cycle pulse for each mismatching sample
- err_index  out  IDX_W  index of the most recent mismatch
- err_count  out  CNT_W  mismatches this run; saturates at all-ones
- first_err_index  out  IDX_W  index of the first mismatch; held until the next start
- first_err_exp / first_err_obs  out  WIDTH  expected and observed values at the first mismatch

## Operation
- States: IDLE → RUN → DONE. From DONE, start returns to RUN. rst forces IDLE from any state.
- Trace memory is DEPTH × (WIDTH+1): WIDTH data bits plus one skip bit. Loading happens only in IDLE. load_we is ignored in RUN and DONE, and the memory is left unchanged.
- On start:
  - latch trace_len
  - clear the index, divider, err_count and the first_err_* registers
  - clear pass
- If the latched trace_len is 0, the block goes directly to DONE with pass=1.
- trace_len > DEPTH is clamped to DEPTH.
- Divider: counts from 0 to DIV-1 in RUN. The strobe fires when the divider equals DIV-1.
- Match rule: the skip bit is set, or obs === mem[index]. Any X/Z bit in obs counts as a mismatch in simulation.
- On a mismatch strobe:
  - err_count increments unless already all-ones
  - err_index is updated
  - first_err_* is captured only if err_count was 0
- After the strobe for index = trace_len-1, go to DONE. pass = (err_count == 0), including the last sample.
- start while in RUN is ignored.
- The memory has no reset. Contents survive rst.

## Timing
- Reset values: busy=0, done=0, pass=0, err_valid=0, err_index=0, err_count=0, first_err_*=0, state=IDLE.
- First strobe: DIV cycles after the start cycle. obs is sampled on that edge.
- Subsequent strobes: every DIV cycles.
- err_valid, err_count and first_err_* update one cycle after the strobe edge (registered compare). err_valid is high for exactly one cycle.
- done and pass assert in the same cycle as the final err_count update.
- Total run: trace_len·DIV + 1 cycles from start to done.
- DIV=1: a strobe every cycle, with back-to-back err_valid pulses allowed.
- A load_we in the same cycle as start is ignored.
- rst during RUN: IDLE on the next edge, with all outputs at their reset values.

## Structure
- Shared package trace_pkg holds:
  - the state enum {IDLE, RUN, DONE}
  - the entry struct {skip, data}
  - the default parameter constants
- One sub-module, trace_mem: a single-port-write, async-read DEPTH×(WIDTH+1) array. Its read index comes from the checker.
- The checker FSM, divider and counters live in trace_checker.

## Test plan
- All-match run: load 24 entries 00..17, trace_len=24, DIV=2, drive obs = entry per strobe → 0 err_valid pulses; done at start+49; pass=1; err_count=0.
- Single mismatch: as above, but obs=FF at index 5 → one err_valid pulse; err_index=5; first_err_exp=05; first_err_obs=FF; pass=0.
- Skip entry: entry 3 loaded with skip=1, obs=AA at index 3 → no error; pass=1.
- Saturation: CNT_W=2, 6 mismatches → err_count stops at 3; first_err_index is the earliest mismatch.
- Boundaries:
  - trace_len=0 → done the next cycle with pass=1.
  - trace_len=40 with DEPTH=32 → exactly 32 strobes.
  - start during RUN is ignored.
  - load_we during RUN leaves the memory unchanged.
- Reset mid-run: assert rst at strobe 10 → IDLE and all outputs zero next cycle. A re-start without reload rechecks the preserved trace and passes.
